muldiv_seq: RTL and testbench

//  Multi-cycle multiply/divide sequencer with the architectural HI/LO registers, attached to the EX stage.

---
 rtl/muldiv_seq_pkg.sv | 14 +
 rtl/muldiv_seq_iter_core.sv | 35 +++
 rtl/muldiv_seq.sv | 116 +++++++++++
 tb/tb_muldiv_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: op encodings, FSM states and divide-by-zero constant for the multiply/divide sequencer
package muldiv_seq_pkg;
  localparam logic [2:0] MDU_OP_MULT  = 3'd0;
  localparam logic [2:0] MDU_OP_MULTU = 3'd1;
  localparam logic [2:0] MDU_OP_DIV   = 3'd2;
  localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
  localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
  localparam logic [2:0] MDU_OP_MTLO  = 3'd5;
  localparam logic [31:0] MDU_DIV0_LO = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {MDU_S_IDLE, MDU_S_RUN, MDU_S_FIX} mdu_state_e;
  function automatic logic is_md(input logic [2:0] o);
    return ~o[2];
  endfunction
endpackage

// File: rtl/muldiv_seq_iter_core.sv
// muldiv_seq_iter_core: 64-bit shift register plus 33-bit add/sub, one restoring-divide or shift-add-multiply step per i_step
module muldiv_seq_iter_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_step,
  input  logic        i_div,
  input  logic [31:0] i_a,
  input  logic [31:0] i_m,
  output logic [63:0] o_acc
);
  logic [63:0] r_acc, w_nx;
  logic [31:0] r_m;
  logic [33:0] w_sub;
  logic [32:0] w_add;
  // Divide keeps remainder in [63:32] and shifts quotient bits into [31:0]; multiply keeps the partial product on top.
  always_comb begin
    w_sub = {1'b0, r_acc[63:31]} - {2'b0, r_m};
    w_add = {1'b0, r_acc[63:32]} + {1'b0, r_m};
    w_nx  = i_div ? ((w_sub[33:32] == 2'b00) ? {w_sub[31:0], r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0})
                  : (r_acc[0] ? {w_add, r_acc[31:1]} : {1'b0, r_acc[63:1]});
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_m   <= '0;
    end else if (i_load) begin
      r_acc <= {32'b0, i_a};
      r_m   <= i_m;
    end else if (i_step) begin
      r_acc <= w_nx;
    end
  end
  assign o_acc = r_acc;
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: MIPS HI/LO multiply/divide sequencer; define MDU_FAST_MUL_EN for a MUL_LAT-cycle registered multiplier on MULT/MULTU
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int DIV_ITERS = 32
`ifdef MDU_FAST_MUL_EN
  , parameter int MUL_LAT = 2
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rd_hilo,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam logic [5:0] LAST_ITER = 6'(DIV_ITERS - 1);
  mdu_state_e r_state, w_next;
  logic [5:0]  r_cnt;
  logic [31:0] r_a, r_hi, r_lo;
  logic        r_is_div, r_neg_q, r_neg_r, r_div0, r_done;
  logic        w_idle, w_accept, w_mt, w_fast, w_last, w_write, w_step, w_sa, w_sb;
  logic [63:0] w_acc, w_mul;
  logic [31:0] w_q, w_r, w_hi_new, w_lo_new;
  assign w_idle   = r_state == MDU_S_IDLE;
  assign w_accept = start & ~flush & is_md(op) & w_idle;
  assign w_mt     = start & ~flush & ((op == MDU_OP_MTHI) | (op == MDU_OP_MTLO)) & w_idle;
  assign w_sa     = ~op[0] & rs_val[31];
  assign w_sb     = ~op[0] & rt_val[31];
`ifdef MDU_FAST_MUL_EN
  logic [31:0] r_b;
  logic        r_signed;
  assign w_fast = ~r_is_div;
  assign w_last = w_fast ? (r_cnt == 6'(MUL_LAT - 1)) : (r_cnt == LAST_ITER);
  assign w_mul  = $signed({{32{r_signed & r_a[31]}}, r_a}) * $signed({{32{r_signed & r_b[31]}}, r_b});
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b      <= '0;
      r_signed <= 1'b0;
    end else if (w_accept) begin
      r_b      <= rt_val;
      r_signed <= ~op[0];
    end
  end
`else
  assign w_fast = 1'b0;
  assign w_last = r_cnt == LAST_ITER;
  assign w_mul  = r_neg_q ? -w_acc : w_acc;
`endif
  // Magnitude datapath; signs are reapplied when the result is written back.
  assign w_q      = r_neg_q ? -w_acc[31:0] : w_acc[31:0];
  assign w_r      = r_neg_r ? -w_acc[63:32] : w_acc[63:32];
  assign w_hi_new = r_is_div ? (r_div0 ? r_a : w_r) : w_mul[63:32];
  assign w_lo_new = r_is_div ? (r_div0 ? MDU_DIV0_LO : w_q) : w_mul[31:0];
  assign w_write  = ~flush & ((r_state == MDU_S_FIX) | ((r_state == MDU_S_RUN) & w_last & w_fast));
  muldiv_seq_iter_core u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_step (w_step),
    .i_div  (r_is_div),
    .i_a    (w_sa ? -rs_val : rs_val),
    .i_m    (w_sb ? -rt_val : rt_val),
    .o_acc  (w_acc)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MDU_S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = flush ? MDU_S_IDLE
           : w_idle ? (w_accept ? MDU_S_RUN : MDU_S_IDLE)
           : (r_state == MDU_S_RUN) ? (w_last ? (w_fast ? MDU_S_IDLE : MDU_S_FIX) : MDU_S_RUN)
           : MDU_S_IDLE;
  end
  always_comb begin
    busy   = ~w_idle;
    stall  = (start | rd_hilo) & busy;
    w_step = (r_state == MDU_S_RUN) & ~w_fast;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= w_write;
      r_cnt  <= w_accept ? 6'd0 : (r_state == MDU_S_RUN) ? r_cnt + 6'd1 : r_cnt;
      if (w_accept) begin
        r_a      <= rs_val;
        r_is_div <= op[1];
        r_neg_q  <= w_sa ^ w_sb;
        r_neg_r  <= w_sa;
        r_div0   <= rt_val == 32'd0;
      end
      r_hi <= w_write ? w_hi_new : (w_mt & (op == MDU_OP_MTHI)) ? rs_val : r_hi;
      r_lo <= w_write ? w_lo_new : (w_mt & (op == MDU_OP_MTLO)) ? rs_val : r_lo;
    end
  end
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed checks of muldiv_seq against a plain-arithmetic HI/LO model
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_N = 2;
`else
  localparam int MUL_N = 33;
`endif
  logic        clk, rst_n, start, rd_hilo, flush, busy, stall, done;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val, hi, lo;
  int n_chk = 0;
  int n_fail = 0;

  muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .rd_hilo(rd_hilo), .flush(flush), .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, p;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = 32'd0;
    el = 32'd0;
    if (o == MDU_OP_MULT) begin
      p = sa * sb;
      eh = p[63:32];
      el = p[31:0];
    end else if (o == MDU_OP_MULTU) begin
      u = {32'd0, a} * {32'd0, b};
      eh = u[63:32];
      el = u[31:0];
    end else if (b == 32'd0) begin
      eh = a;
      el = 32'hFFFF_FFFF;
    end else if (o == MDU_OP_DIV) begin
      p = sa / sb;
      el = p[31:0];
      p = sa % sb;
      eh = p[31:0];
    end else begin
      el = a / b;
      eh = a % b;
    end
  endfunction

  task automatic pulse(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string nm);
    logic [31:0] eh, el;
    int n, exp_n;
    bit busy_drop;
    model(o, a, b, eh, el);
    exp_n = o[1] ? 33 : MUL_N;
    pulse(o, a, b);
    rs_val = $urandom; rt_val = $urandom;
    n = 0; busy_drop = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy !== 1'b1) busy_drop = 1;
      @(posedge clk); #1;
      n++;
    end
    n_chk++; if (n != exp_n) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", nm, n, exp_n); end
    n_chk++; if (busy_drop) begin n_fail++; $display("FAIL %s busy_hold: got dropped expected held", nm); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_end: got %b expected 0", nm, busy); end
    n_chk++; if (hi !== eh) begin n_fail++; $display("FAIL %s hi: got %h expected %h", nm, hi, eh); end
    n_chk++; if (lo !== el) begin n_fail++; $display("FAIL %s lo: got %h expected %h", nm, lo, el); end
    @(posedge clk); #1;
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s done_pulse: got %b expected 0", nm, done); end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; op = 3'd0; rs_val = 32'd0; rt_val = 32'd0; rd_hilo = 1'b0; flush = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if ({busy, done, stall} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, done, stall}); end
    n_chk++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
    n_chk++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_div();
    run_op(MDU_OP_DIVU, 32'd100, 32'd7, "divu_100_7");
    run_op(MDU_OP_DIV, -32'sd7, 32'd2, "div_m7_2");
    run_op(MDU_OP_DIV, 32'd7, -32'sd2, "div_7_m2");
  endtask

  task automatic test_mult();
    run_op(MDU_OP_MULT, 32'hFFFF_FFFF, 32'd2, "mult_m1_2");
    run_op(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'd2, "multu_ffff_2");
  endtask

  task automatic test_div0_mthi();
    logic [31:0] old_lo;
    run_op(MDU_OP_DIVU, 32'd5, 32'd0, "divu_5_0");
    old_lo = lo;
    pulse(MDU_OP_MTHI, 32'h1234, 32'd0);
    n_chk++; if (hi !== 32'h1234) begin n_fail++; $display("FAIL mthi_hi: got %h expected 00001234", hi); end
    n_chk++; if (lo !== old_lo) begin n_fail++; $display("FAIL mthi_lo: got %h expected %h", lo, old_lo); end
    n_chk++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL mthi_flags: got %b expected 00", {busy, done}); end
    pulse(MDU_OP_MTLO, 32'h5A5A_0002, 32'd0);
    n_chk++; if (lo !== 32'h5A5A_0002) begin n_fail++; $display("FAIL mtlo_lo: got %h expected 5a5a0002", lo); end
  endtask

  task automatic test_stall_flush();
    bit saw_done;
    pulse(MDU_OP_MTHI, 32'hA5A5_0001, 32'd0);
    pulse(MDU_OP_DIV, -32'sd100, 32'd3);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 3) begin
        start = 1'b1; op = MDU_OP_MTLO; rs_val = 32'hFFFF_0000;
        #1;
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_start_busy: got %b expected 1", stall); end
      end
      if (c == 4) start = 1'b0;
      if (c >= 5 && c <= 9) begin
        rd_hilo = 1'b1;
        #1;
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_rd_hilo c%0d: got %b expected 1", c, stall); end
      end
      if (c == 10) begin rd_hilo = 1'b0; flush = 1'b1; end
    end
    @(posedge clk); #1;
    flush = 1'b0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", busy); end
    n_chk++; if (hi !== 32'hA5A5_0001 || lo !== 32'h5A5A_0002) begin n_fail++; $display("FAIL flush_hilo: got %h_%h expected a5a50001_5a5a0002", hi, lo); end
    saw_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) saw_done = 1;
      @(posedge clk); #1;
    end
    n_chk++; if (saw_done) begin n_fail++; $display("FAIL flush_no_done: got 1 expected 0"); end
  endtask

  task automatic test_flush_final();
    pulse(MDU_OP_DIVU, 32'd50, 32'd5);
    for (int c = 1; c <= 32; c++) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_chk++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL flush_final_flags: got %b expected 00", {busy, done}); end
    n_chk++; if (lo !== 32'h5A5A_0002) begin n_fail++; $display("FAIL flush_final_lo: got %h expected 5a5a0002", lo); end
  endtask

  task automatic test_undef();
    logic [31:0] oh, ol;
    oh = hi; ol = lo;
    pulse(3'd6, $urandom, $urandom);
    pulse(3'd7, $urandom, $urandom);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL undef_busy: got %b expected 0", busy); end
    n_chk++; if (hi !== oh || lo !== ol) begin n_fail++; $display("FAIL undef_hilo: got %h_%h expected %h_%h", hi, lo, oh, ol); end
  endtask

  task automatic test_back_to_back();
    int n;
    start = 1'b1; op = MDU_OP_DIVU; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1;
    op = MDU_OP_MULTU; rs_val = 32'd3; rt_val = 32'd5;
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall: got %b expected 1", stall); end
    n = 0;
    while (done !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    n_chk++; if (n != 33 || lo !== 32'd14 || hi !== 32'd2) begin n_fail++; $display("FAIL b2b_first: got n=%0d %h_%h expected n=33 00000002_0000000e", n, hi, lo); end
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    n_chk++; if (n != MUL_N || lo !== 32'd15 || hi !== 32'd0) begin n_fail++; $display("FAIL b2b_second: got n=%0d %h_%h expected n=%0d 00000000_0000000f", n, hi, lo, MUL_N); end
  endtask

  task automatic test_async_reset();
    pulse(MDU_OP_DIV, 32'd1000, -32'sd7);
    for (int c = 1; c <= 20; c++) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL arst_flags: got %b expected 00", {busy, done}); end
    n_chk++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL arst_hilo: got %h_%h expected 0_0", hi, lo); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(MDU_OP_DIVU, 32'd9, 32'd3, "divu_9_3");
  endtask

  task automatic test_random();
    logic [2:0] o;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      o = 3'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      run_op(o, a, b, $sformatf("rand%0d_op%0d", i, o));
    end
  endtask

  initial begin
    test_reset();
    test_div();
    test_mult();
    test_div0_mthi();
    test_stall_flush();
    test_flush_final();
    test_undef();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
